// File: rtl/coreapb3_bfm_apb_slave_pkg.sv
// Shared definitions for the APB3 completer BFM: FSM states, protocol
// violation cause codes, wait-counter width and the LFSR next-state rule.
package coreapb3_bfm_apb_slave_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_t;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_NO_SETUP  = 2'b01;
    localparam logic [1:0] CAUSE_PSEL_DROP = 2'b10;
    localparam logic [1:0] CAUSE_CHANGED   = 2'b11;

    localparam int WAIT_W = 4;

    // Fibonacci step for x^16+x^14+x^13+x^11+1: shift left, feedback into bit 0
    function automatic logic [15:0] lfsr16Next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

endpackage

// File: rtl/coreapb3_bfm_apb_slave_lfsr16.sv
// 16-bit Fibonacci LFSR that advances only when asked; supplies the
// pseudo-random wait counts of the completer.
module coreapb3_bfm_apb_slave_lfsr16
    import coreapb3_bfm_apb_slave_pkg::*;
(
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // Reload the seed on reset, advance one position per requested step
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr16Next(q);
        end
    end

endmodule

// File: rtl/coreapb3_bfm_apb_slave.sv
// APB3 completer BFM: word memory behind one PSEL slot, fixed or LFSR-driven
// wait states, PSLVERR on out-of-range or misaligned addresses, and a sticky
// checker for initiator protocol violations.
module coreapb3_bfm_apb_slave
    import coreapb3_bfm_apb_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          AWIDTH      = 10,
    parameter int          WAIT_STATES = 0,
    parameter bit          RAND_WAIT   = 1'b0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        PROT_ERR,
    output logic [1:0]  ERR_CAUSE,
    output logic [15:0] XFER_CNT
);

    localparam int                DEPTH     = 2 ** AWIDTH;
    localparam logic [32:0]       SPAN      = 33'(1) << (AWIDTH + 2);
    localparam logic [WAIT_W-1:0] WAIT_MASK = WAIT_W'(WAIT_STATES);

    apb_state_t        r_state;
    logic [WAIT_W-1:0] r_cnt;
    logic [31:0]       r_addr;
    logic [AWIDTH-1:0] r_idx;
    logic              r_write;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [31:0]       r_rdq;
    logic              r_prot_err;
    logic [1:0]        r_cause;
    logic [15:0]       r_xfer_cnt;
    logic [31:0]       r_mem [DEPTH];

    logic [31:0]       w_offset;
    logic [AWIDTH-1:0] w_idx;
    logic              w_addr_err;
    logic              w_setup;
    logic              w_ready;
    logic              w_complete;
    logic [15:0]       w_lfsr;
    logic [WAIT_W-1:0] w_wait_load;
    logic              w_viol;
    logic [1:0]        w_viol_cause;
    logic              w_unused_lfsr;

    assign w_offset    = PADDR - BASE_ADDR;
    assign w_idx       = w_offset[AWIDTH+1:2];
    assign w_addr_err  = (PADDR < BASE_ADDR) || ({1'b0, w_offset} >= SPAN) || (PADDR[1:0] != 2'b00);
    assign w_setup     = (r_state == ST_IDLE) && PSEL && !PENABLE;
    assign w_ready     = (r_state == ST_ACCESS) && (r_cnt == '0);
    assign w_complete  = w_ready && PSEL && PENABLE;
    assign w_wait_load = RAND_WAIT ? (w_lfsr[WAIT_W-1:0] & WAIT_MASK) : WAIT_MASK;
    assign w_unused_lfsr = ^w_lfsr[15:WAIT_W];

    assign PREADY    = w_ready;
    assign PSLVERR   = w_ready && r_err;
    assign PRDATA    = (w_ready && !r_write && !r_err) ? r_rdq : 32'h0;
    assign PROT_ERR  = r_prot_err;
    assign ERR_CAUSE = r_cause;
    assign XFER_CNT  = r_xfer_cnt;

    coreapb3_bfm_apb_slave_lfsr16 u_lfsr (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .step   (w_setup),
        .seed   (LFSR_SEED),
        .q      (w_lfsr)
    );

    // Classify the current cycle against the APB3 handshake; a dropped PSEL
    // takes priority so that signal-change checks only apply while selected
    always_comb begin
        w_viol       = 1'b0;
        w_viol_cause = CAUSE_NONE;
        if (r_state == ST_IDLE && PSEL && PENABLE) begin
            w_viol       = 1'b1;
            w_viol_cause = CAUSE_NO_SETUP;
        end else if (r_state == ST_ACCESS && !PSEL) begin
            w_viol       = 1'b1;
            w_viol_cause = CAUSE_PSEL_DROP;
        end else if (r_state == ST_ACCESS &&
                     (PADDR != r_addr || PWRITE != r_write || PWDATA != r_wdata)) begin
            w_viol       = 1'b1;
            w_viol_cause = CAUSE_CHANGED;
        end
    end

    // Transfer FSM: capture on setup, count down waits, retire on completion;
    // the checker keeps only the first violation cause
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_idx      <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_rdq      <= '0;
            r_prot_err <= 1'b0;
            r_cause    <= CAUSE_NONE;
            r_xfer_cnt <= '0;
        end else begin
            if (w_viol) begin
                r_prot_err <= 1'b1;
                if (!r_prot_err) begin
                    r_cause <= w_viol_cause;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_setup) begin
                        r_addr  <= PADDR;
                        r_idx   <= w_idx;
                        r_write <= PWRITE;
                        r_wdata <= PWDATA;
                        r_err   <= w_addr_err;
                        r_cnt   <= w_wait_load;
                        r_rdq   <= r_mem[w_idx];
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!PSEL) begin
                        r_state <= ST_IDLE;
                    end else if (w_complete) begin
                        r_xfer_cnt <= r_xfer_cnt + 16'd1;
                        r_state    <= ST_IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Memory is not reset; writes commit on the completion edge using the
    // values captured at setup
    always_ff @(posedge PCLK) begin
        if (w_complete && r_write && !r_err) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_coreapb3_bfm_apb_slave.sv
// Self-checking bench for the APB3 completer BFM: three instances (no wait,
// fixed three waits, masked LFSR waits) compared against a behavioural model.
module tb_coreapb3_bfm_apb_slave;

    localparam logic [31:0] BASE_A = 32'h0000_1000;
    localparam logic [31:0] BASE_B = 32'h0004_0000;
    localparam int          SEED   = 16'hACE1;

    logic        clock;
    logic        preset;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata [3];
    logic [2:0]  pready;
    logic [2:0]  pslverr;
    logic [2:0]  protErr;
    logic [1:0]  errCause [3];
    logic [15:0] xferCnt [3];

    int          vectors;
    int          miscompares;
    logic [31:0] bases [3];
    int          depths [3];
    logic [31:0] memModel [3][64];
    bit          known [3][64];
    int          xfers [3];
    int          lfsrModel;

    coreapb3_bfm_apb_slave #(.BASE_ADDR(BASE_A), .AWIDTH(4), .WAIT_STATES(0),
                             .RAND_WAIT(1'b0), .LFSR_SEED(16'hACE1)) u_zero (
        .PCLK(clock), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]),
        .PREADY(pready[0]), .PSLVERR(pslverr[0]), .PROT_ERR(protErr[0]),
        .ERR_CAUSE(errCause[0]), .XFER_CNT(xferCnt[0]));

    coreapb3_bfm_apb_slave #(.BASE_ADDR(BASE_A), .AWIDTH(4), .WAIT_STATES(3),
                             .RAND_WAIT(1'b0), .LFSR_SEED(16'hACE1)) u_fixed (
        .PCLK(clock), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]),
        .PREADY(pready[1]), .PSLVERR(pslverr[1]), .PROT_ERR(protErr[1]),
        .ERR_CAUSE(errCause[1]), .XFER_CNT(xferCnt[1]));

    coreapb3_bfm_apb_slave #(.BASE_ADDR(BASE_B), .AWIDTH(6), .WAIT_STATES(15),
                             .RAND_WAIT(1'b1), .LFSR_SEED(16'hACE1)) u_rand (
        .PCLK(clock), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]),
        .PREADY(pready[2]), .PSLVERR(pslverr[2]), .PROT_ERR(protErr[2]),
        .ERR_CAUSE(errCause[2]), .XFER_CNT(xferCnt[2]));

    // Free-running 100 MHz clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Absolute time limit so a stuck design still ends the run
    initial begin
        #5ms;
        $display("[TB] FAIL timeout: simulation still running, expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    // Polynomial x^16+x^14+x^13+x^11+1 evaluated arithmetically
    function automatic int nextLfsr(input int v);
        int fb;
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return ((v << 1) | fb) & 16'hFFFF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        for (int k = 0; k < 3; k++) begin
            checkOutput({tag, "_pready"},  32'(pready[k]),   32'd0);
            checkOutput({tag, "_pslverr"}, 32'(pslverr[k]),  32'd0);
            checkOutput({tag, "_prdata"},  prdata[k],        32'd0);
            checkOutput({tag, "_proterr"}, 32'(protErr[k]),  32'd0);
            checkOutput({tag, "_cause"},   32'(errCause[k]), 32'd0);
            checkOutput({tag, "_xfercnt"}, 32'(xferCnt[k]),  32'd0);
        end
    endtask

    // One complete APB transfer on slot k; expectations come from the model
    task automatic applyStimulus(input int k, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data);
        longint      a;
        longint      lo;
        longint      hi;
        logic        err;
        int          idx;
        int          waits;
        logic [31:0] expRd;
        bit          chkRd;
        a     = longint'(addr);
        lo    = longint'(bases[k]);
        hi    = lo + 4 * depths[k];
        err   = (a < lo) || (a >= hi) || (addr[1:0] != 2'b00);
        idx   = err ? 0 : int'((a - lo) / 4);
        if (k == 0) begin
            waits = 0;
        end else if (k == 1) begin
            waits = 3;
        end else begin
            waits     = lfsrModel % 16;
            lfsrModel = nextLfsr(lfsrModel);
        end
        expRd = 32'h0;
        chkRd = 1'b1;
        if (!wr && !err) begin
            chkRd = known[k][idx];
            expRd = memModel[k][idx];
        end
        psel[k] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(negedge clock);
        penable = 1'b1;
        for (int j = 0; j <= waits; j++) begin
            if (j > 0) @(negedge clock);
            checkOutput("pready",  32'(pready[k]),  (j == waits) ? 32'd1 : 32'd0);
            checkOutput("pslverr", 32'(pslverr[k]), (j == waits && err) ? 32'd1 : 32'd0);
        end
        if (chkRd) checkOutput("prdata", prdata[k], expRd);
        @(negedge clock);
        psel[k] = 1'b0;
        penable = 1'b0;
        if (wr && !err) begin
            memModel[k][idx] = data;
            known[k][idx]    = 1'b1;
        end
        xfers[k]++;
        checkOutput("xfer_cnt", 32'(xferCnt[k]), 32'(xfers[k] & 16'hFFFF));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        bases[0] = BASE_A; bases[1] = BASE_A; bases[2] = BASE_B;
        depths[0] = 16;    depths[1] = 16;    depths[2] = 64;
        for (int k = 0; k < 3; k++) xfers[k] = 0;
        lfsrModel = SEED;
        preset  = 1'b1;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 32'h0;
        repeat (3) @(negedge clock);
        checkIdle("reset");
        preset = 1'b0;
        @(negedge clock);

        // Zero-wait write/read, back to back
        applyStimulus(0, 1'b1, BASE_A + 32'h10, 32'hDEADBEEF);
        applyStimulus(0, 1'b0, BASE_A + 32'h10, 32'h0);
        applyStimulus(0, 1'b1, BASE_A + 32'h3C, 32'h0BADF00D);
        applyStimulus(0, 1'b0, BASE_A + 32'h3C, 32'h0);

        // Address errors: past the end, misaligned, below base; writes must not land
        applyStimulus(0, 1'b0, BASE_A + 32'h40, 32'h0);
        applyStimulus(0, 1'b0, BASE_A + 32'h02, 32'h0);
        applyStimulus(0, 1'b1, BASE_A + 32'h40, 32'h11111111);
        applyStimulus(0, 1'b1, BASE_A + 32'h12, 32'h22222222);
        applyStimulus(0, 1'b1, BASE_A - 32'h4,  32'h33333333);
        applyStimulus(0, 1'b0, BASE_A + 32'h10, 32'h0);

        // Three fixed wait states
        applyStimulus(1, 1'b1, BASE_A + 32'h10, 32'hA5A5_0001);
        applyStimulus(1, 1'b0, BASE_A + 32'h10, 32'h0);
        applyStimulus(1, 1'b1, BASE_A + 32'h1C, 32'h13579BDF);

        // Access phase without setup: cause 01, nothing transferred
        applyStimulus(0, 1'b1, BASE_A + 32'h20, 32'h11112222);
        psel[0] = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = BASE_A;
        @(negedge clock);
        checkOutput("nosetup_proterr", 32'(protErr[0]),  32'd1);
        checkOutput("nosetup_cause",   32'(errCause[0]), 32'd1);
        checkOutput("nosetup_xfercnt", 32'(xferCnt[0]),  32'(xfers[0]));
        psel[0] = 1'b0;
        penable = 1'b0;

        // PSEL dropped during access: aborted, first cause retained
        psel[0] = 1'b1;
        pwrite  = 1'b1;
        paddr   = BASE_A + 32'h20;
        pwdata  = 32'h55AA55AA;
        @(negedge clock);
        psel[0] = 1'b0;
        penable = 1'b1;
        @(negedge clock);
        penable = 1'b0;
        checkOutput("drop_cause",   32'(errCause[0]), 32'd1);
        checkOutput("drop_xfercnt", 32'(xferCnt[0]),  32'(xfers[0]));
        checkOutput("drop_pready",  32'(pready[0]),   32'd0);
        applyStimulus(0, 1'b0, BASE_A + 32'h20, 32'h0);

        // Address changed during access: cause 11, captured address is written
        psel[1] = 1'b1;
        pwrite  = 1'b1;
        paddr   = BASE_A + 32'h18;
        pwdata  = 32'hCAFEF00D;
        @(negedge clock);
        penable = 1'b1;
        paddr   = BASE_A + 32'h1C;
        for (int j = 0; j <= 3; j++) begin
            if (j > 0) @(negedge clock);
            checkOutput("chg_pready", 32'(pready[1]), (j == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clock);
        psel[1] = 1'b0;
        penable = 1'b0;
        memModel[1][6] = 32'hCAFEF00D;
        known[1][6]    = 1'b1;
        xfers[1]++;
        checkOutput("chg_proterr", 32'(protErr[1]),  32'd1);
        checkOutput("chg_cause",   32'(errCause[1]), 32'd3);
        checkOutput("chg_xfercnt", 32'(xferCnt[1]),  32'(xfers[1]));
        applyStimulus(1, 1'b0, BASE_A + 32'h18, 32'h0);
        applyStimulus(1, 1'b0, BASE_A + 32'h1C, 32'h0);

        // Reset during a wait state of a write: aborted, memory untouched
        psel[1] = 1'b1;
        pwrite  = 1'b1;
        paddr   = BASE_A + 32'h10;
        pwdata  = 32'hBAD0BAD0;
        @(negedge clock);
        penable = 1'b1;
        @(negedge clock);
        preset = 1'b1;
        #1;
        checkIdle("midreset");
        for (int k = 0; k < 3; k++) xfers[k] = 0;
        lfsrModel = SEED;
        @(negedge clock);
        preset  = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        @(negedge clock);
        applyStimulus(1, 1'b0, BASE_A + 32'h10, 32'h0);
        applyStimulus(0, 1'b0, BASE_A + 32'h10, 32'h0);

        // Random traffic with LFSR-masked waits
        for (int n = 0; n < 1000; n++) begin
            int          r;
            logic [31:0] a;
            r = int'($urandom_range(0, 15));
            if (r == 0)
                a = BASE_B + 32'h100 + 32'(4 * $urandom_range(0, 7));
            else if (r == 1)
                a = BASE_B + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
            else if (r == 2)
                a = BASE_B - 32'(4 * $urandom_range(1, 4));
            else
                a = BASE_B + 32'(4 * $urandom_range(0, 63));
            applyStimulus(2, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clock);
        end
        checkOutput("rand_total",   32'(xferCnt[2]), 32'd1000);
        checkOutput("rand_proterr", 32'(protErr[2]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
